// File: rtl/rv_pkg.sv
// rv_pkg -- shared decode constants for the instruction-decode slice.
//   * RISC-V major opcodes handled by id_stage (plus custom-0 for kNN)
//   * op_class_e : 3-bit instruction class driven on id_stage.op_class
//   * state_e    : decode-stage control FSM states
//   * imm_sel_e  : immediate format selector for imm_gen
//   * NOP_INSN   : value the IF/ID register takes on reset (addi x0,x0,0)
package rv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_KNN    = 7'b0001011;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    OP_R       = 3'd0,
    OP_I       = 3'd1,
    OP_LOAD    = 3'd2,
    OP_STORE   = 3'd3,
    OP_BRANCH  = 3'd4,
    OP_KNN     = 3'd5,
    OP_ILLEGAL = 3'd7
  } op_class_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_KNN   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2
  } imm_sel_e;

  function automatic op_class_e decode_opcode(input logic [6:0] opc);
    op_class_e cls;
    case (opc)
      OPC_R:      cls = OP_R;
      OPC_I:      cls = OP_I;
      OPC_LOAD:   cls = OP_LOAD;
      OPC_STORE:  cls = OP_STORE;
      OPC_BRANCH: cls = OP_BRANCH;
      OPC_KNN:    cls = OP_KNN;
      default:    cls = OP_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen -- combinational immediate assembly for I, S and B formats.
// Ports:
//   sel     in   immediate format (IMM_I / IMM_S / IMM_B)
//   ir_hi   in   instruction bits [31:20]
//   ir_lo   in   instruction bits [11:7]
//   imm_out out  13-bit sign-extended immediate (B keeps its implicit bit 0)
// Only the instruction bits that carry immediate data are passed in, so
// every input bit is consumed by at least one format.
module imm_gen
  import rv_pkg::*;
(
  input  imm_sel_e    sel,
  input  logic [11:0] ir_hi,
  input  logic [4:0]  ir_lo,
  output logic [12:0] imm_out
);

  always_comb begin
    imm_out = '0;
    case (sel)
      IMM_I:   imm_out = {ir_hi[11], ir_hi};
      IMM_S:   imm_out = {ir_hi[11], ir_hi[11:5], ir_lo};
      // {ir[31], ir[7], ir[30:25], ir[11:8], 0}
      IMM_B:   imm_out = {ir_hi[11], ir_lo[0], ir_hi[10:5], ir_lo[4:1], 1'b0};
      default: imm_out = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// id_stage -- instruction decode stage with branch flush and kNN handshake.
// Ports:
//   clock            in   rising-edge clock
//   reset            in   synchronous active-low reset
//   Instruction_Code in   fetched word (registered into IF/ID)
//   is_greater_than  in   branch compare result from execute
//   knn_done         in   completion pulse from the kNN accelerator
//   pc_branch        out  branch request, one cycle per decoded branch
//   imm              out  backward branch distance, (-B_imm)[11:0]
//   id_valid         out  decoded bundle valid this cycle
//   rs1/rs2/rd       out  register fields (zero for ILLEGAL)
//   funct3/funct7    out  raw function fields
//   op_class         out  instruction class (rv_pkg::op_class_e encoding)
//   knn_start        out  one-cycle start pulse to the accelerator
//   stall            out  high from the kNN decode cycle until knn_done
module id_stage
  import rv_pkg::*;
#(
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] Instruction_Code,
  input  logic        is_greater_than,
  input  logic        knn_done,
  output logic        pc_branch,
  output logic [11:0] imm,
  output logic        id_valid,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [2:0]  op_class,
  output logic        knn_start,
  output logic        stall
);

  localparam int CNT_W = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;

  op_class_e        cls;
  logic [12:0]      b_imm;
  logic             branch_dec;
  logic             knn_go;
  logic             fields_en;

  imm_gen u_imm_gen (
    .sel     (IMM_B),
    .ir_hi   (ir_q[31:20]),
    .ir_lo   (ir_q[11:7]),
    .imm_out (b_imm)
  );

  assign cls        = decode_opcode(ir_q[6:0]);
  assign fields_en  = (cls != OP_ILLEGAL);
  // valid_q is only ever set in RUN, so these fire solely on live words.
  assign branch_dec = valid_q && (cls == OP_BRANCH);
  assign knn_go     = valid_q && (cls == OP_KNN) && (state_q == ST_RUN);

  assign op_class  = cls;
  assign id_valid  = valid_q;
  assign rs1       = fields_en ? ir_q[19:15] : 5'd0;
  assign rs2       = fields_en ? ir_q[24:20] : 5'd0;
  assign rd        = fields_en ? ir_q[11:7]  : 5'd0;
  assign funct3    = ir_q[14:12];
  assign funct7    = ir_q[31:25];
  assign imm       = 12'(-b_imm);

  // Combinational controls are forced low while reset is held so a stale
  // state cannot leak a request during the reset cycle.
  assign pc_branch = reset && branch_dec;
  assign knn_start = reset && knn_go;
  // Stall rises in the decode cycle itself so fetch holds the next word.
  assign stall     = reset && (knn_go || (state_q == ST_KNN));

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    case (state_q)
      ST_RUN: begin
        ir_d    = Instruction_Code;
        valid_d = 1'b1;
        // A branch and a kNN op cannot share a decode cycle; branch wins.
        if (branch_dec && is_greater_than && (FLUSH_CYC > 0)) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYC);
          valid_d = 1'b0;
        end else if (knn_go) begin
          state_d = ST_KNN;
          ir_d    = ir_q;
          valid_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        // Squashed words still flow through IF/ID but never become valid,
        // so branch/kNN opcodes inside them are inert.
        ir_d  = Instruction_Code;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_KNN: begin
        // IF/ID is held; leave on the done pulse and take the waiting word.
        if (knn_done) begin
          state_d = ST_RUN;
          ir_d    = Instruction_Code;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_RUN;
      ir_q    <= NOP_INSN;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage -- directed, table-driven bench for id_stage.
// A table of single-word decode vectors is applied back to back in RUN,
// followed by hand-written sequences for reset, branch flush, kNN
// handshake, stray knn_done and reset during kNN.
module tb_id_stage;

  localparam logic [2:0] C_R = 3'd0, C_I = 3'd1, C_LOAD = 3'd2, C_STORE = 3'd3,
                         C_BRANCH = 3'd4, C_KNN = 3'd5, C_ILL = 3'd7;

  localparam logic [31:0] W_ADD  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] W_ADDI = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] W_BLT  = 32'hFE20CCE3; // blt  x1,x2,-8
  localparam logic [31:0] W_KNN0 = 32'h0000000B; // custom-0, all fields 0
  localparam logic [31:0] W_KNN1 = 32'h0020818B; // custom-0, rd=3 rs1=1 rs2=2

  logic        clock;
  logic        reset;
  logic [31:0] Instruction_Code;
  logic        is_greater_than;
  logic        knn_done;
  logic        pc_branch;
  logic [11:0] imm;
  logic        id_valid;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [2:0]  op_class;
  logic        knn_start;
  logic        stall;

  int checks = 0;
  int errors = 0;

  id_stage #(.FLUSH_CYC(2)) dut (
    .clock            (clock),
    .reset            (reset),
    .Instruction_Code (Instruction_Code),
    .is_greater_than  (is_greater_than),
    .knn_done         (knn_done),
    .pc_branch        (pc_branch),
    .imm              (imm),
    .id_valid         (id_valid),
    .rs1              (rs1),
    .rs2              (rs2),
    .rd               (rd),
    .funct3           (funct3),
    .funct7           (funct7),
    .op_class         (op_class),
    .knn_start        (knn_start),
    .stall            (stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] insn;
    logic        pcb;
    logic        chk_imm;
    logic [11:0] imm;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int stall_cnt;

    vecs[0] = '{W_ADD,        1'b0, 1'b0, 12'h000, C_R,      5'd3,  5'd1, 5'd2, 3'd0, 7'h00};
    vecs[1] = '{32'h407302B3, 1'b0, 1'b0, 12'h000, C_R,      5'd5,  5'd6, 5'd7, 3'd0, 7'h20};
    vecs[2] = '{W_ADDI,       1'b0, 1'b0, 12'h000, C_I,      5'd1,  5'd0, 5'd5, 3'd0, 7'h00};
    vecs[3] = '{32'h00812203, 1'b0, 1'b0, 12'h000, C_LOAD,   5'd4,  5'd2, 5'd8, 3'd2, 7'h00};
    vecs[4] = '{32'h0051A623, 1'b0, 1'b0, 12'h000, C_STORE,  5'd12, 5'd3, 5'd5, 3'd2, 7'h00};
    vecs[5] = '{W_BLT,        1'b1, 1'b1, 12'h008, C_BRANCH, 5'd25, 5'd1, 5'd2, 3'd4, 7'h7F};
    vecs[6] = '{32'h0000007F, 1'b0, 1'b0, 12'h000, C_ILL,    5'd0,  5'd0, 5'd0, 3'd0, 7'h00};
    vecs[7] = '{32'hFFFFFFFF, 1'b0, 1'b0, 12'h000, C_ILL,    5'd0,  5'd0, 5'd0, 3'd7, 7'h7F};
    vecs[8] = '{32'h00000863, 1'b1, 1'b1, 12'hFF0, C_BRANCH, 5'd16, 5'd0, 5'd0, 3'd0, 7'h00};
    vecs[9] = '{32'h00000013, 1'b0, 1'b0, 12'h000, C_I,      5'd0,  5'd0, 5'd0, 3'd0, 7'h00};

    // ---------------- reset held for three cycles ----------------
    reset = 1'b0;
    Instruction_Code = 32'hFFFFFFFF;
    is_greater_than = 1'b0;
    knn_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_pc_branch", 32'(pc_branch), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_knn_start", 32'(knn_start), 32'd0);
      $display("reset cycle %0d id_valid=%0b stall=%0b", k, id_valid, stall);
    end
    reset = 1'b1;
    tick();
    chk("rel_op_class", 32'(op_class), 32'(C_ILL));
    chk("rel_id_valid", 32'(id_valid), 32'd1);
    chk("rel_rd", 32'(rd), 32'd0);
    $display("release word=ffffffff op_class=%0d id_valid=%0b", op_class, id_valid);

    // ---------------- decode table (no taken branches) ----------------
    for (int i = 0; i < 10; i++) begin
      Instruction_Code = vecs[i].insn;
      is_greater_than = 1'b0;
      tick();
      chk("tbl_pc_branch", 32'(pc_branch), 32'(vecs[i].pcb));
      if (vecs[i].chk_imm) chk("tbl_imm", 32'(imm), 32'(vecs[i].imm));
      chk("tbl_id_valid", 32'(id_valid), 32'd1);
      chk("tbl_op_class", 32'(op_class), 32'(vecs[i].op));
      chk("tbl_rd", 32'(rd), 32'(vecs[i].rd));
      chk("tbl_rs1", 32'(rs1), 32'(vecs[i].rs1));
      chk("tbl_rs2", 32'(rs2), 32'(vecs[i].rs2));
      chk("tbl_funct3", 32'(funct3), 32'(vecs[i].f3));
      chk("tbl_funct7", 32'(funct7), 32'(vecs[i].f7));
      chk("tbl_stall", 32'(stall), 32'd0);
      chk("tbl_knn_start", 32'(knn_start), 32'd0);
      $display("vec %0d insn=%h op_class=%0d rd=%0d rs1=%0d rs2=%0d pc_branch=%0b imm=%h",
               i, vecs[i].insn, op_class, rd, rs1, rs2, pc_branch, imm);
    end

    // ---------------- taken branch: two squashed words ----------------
    Instruction_Code = W_BLT;
    is_greater_than = 1'b1;
    tick();
    chk("tk_pc_branch", 32'(pc_branch), 32'd1);
    chk("tk_imm", 32'(imm), 32'h008);
    chk("tk_id_valid", 32'(id_valid), 32'd1);
    $display("taken branch pc_branch=%0b imm=%h", pc_branch, imm);
    Instruction_Code = W_BLT;          // squashed branch must not fire
    tick();
    chk("tk_sq1_valid", 32'(id_valid), 32'd0);
    chk("tk_sq1_pc_branch", 32'(pc_branch), 32'd0);
    $display("squash 1 id_valid=%0b pc_branch=%0b", id_valid, pc_branch);
    Instruction_Code = W_KNN0;         // squashed kNN op must not start
    tick();
    chk("tk_sq2_valid", 32'(id_valid), 32'd0);
    chk("tk_sq2_knn_start", 32'(knn_start), 32'd0);
    chk("tk_sq2_stall", 32'(stall), 32'd0);
    $display("squash 2 id_valid=%0b knn_start=%0b", id_valid, knn_start);
    Instruction_Code = W_ADD;
    is_greater_than = 1'b0;
    tick();
    chk("tk_resume_valid", 32'(id_valid), 32'd1);
    chk("tk_resume_op", 32'(op_class), 32'(C_R));
    chk("tk_resume_pc_branch", 32'(pc_branch), 32'd0);
    $display("resume id_valid=%0b op_class=%0d", id_valid, op_class);
    Instruction_Code = W_ADDI;
    tick();
    chk("tk_after_stall", 32'(stall), 32'd0);
    chk("tk_after_op", 32'(op_class), 32'(C_I));
    chk("tk_after_valid", 32'(id_valid), 32'd1);

    // ---------------- not-taken branch ----------------
    Instruction_Code = W_BLT;
    is_greater_than = 1'b0;
    tick();
    chk("nt_pc_branch", 32'(pc_branch), 32'd1);
    chk("nt_id_valid", 32'(id_valid), 32'd1);
    Instruction_Code = W_ADD;
    tick();
    chk("nt_next_valid", 32'(id_valid), 32'd1);
    chk("nt_next_op", 32'(op_class), 32'(C_R));
    chk("nt_next_pc_branch", 32'(pc_branch), 32'd0);
    $display("not taken next id_valid=%0b op_class=%0d", id_valid, op_class);

    // ---------------- kNN handshake, done 5 cycles after start ----------------
    stall_cnt = 0;
    Instruction_Code = W_KNN0;
    tick();
    chk("knn_start_pulse", 32'(knn_start), 32'd1);
    chk("knn_stall0", 32'(stall), 32'd1);
    chk("knn_op", 32'(op_class), 32'(C_KNN));
    if (stall) stall_cnt++;
    Instruction_Code = W_ADD;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("knn_start_low", 32'(knn_start), 32'd0);
      chk("knn_stall", 32'(stall), 32'd1);
      chk("knn_op_held", 32'(op_class), 32'(C_KNN));
      chk("knn_rd_held", 32'(rd), 32'd0);
      chk("knn_rs1_held", 32'(rs1), 32'd0);
      if (stall) stall_cnt++;
      $display("knn wait %0d stall=%0b knn_start=%0b", k, stall, knn_start);
      if (k == 5) knn_done = 1'b1;
    end
    tick();
    knn_done = 1'b0;
    if (stall) stall_cnt++;
    chk("knn_exit_stall", 32'(stall), 32'd0);
    chk("knn_exit_valid", 32'(id_valid), 32'd1);
    chk("knn_exit_op", 32'(op_class), 32'(C_R));
    chk("knn_exit_start", 32'(knn_start), 32'd0);
    chk("knn_stall_cycles", 32'(stall_cnt), 32'd6);
    $display("knn exit stall_cycles=%0d op_class=%0d", stall_cnt, op_class);

    // ---------------- stray knn_done in RUN ----------------
    Instruction_Code = W_ADDI;
    knn_done = 1'b1;
    tick();
    knn_done = 1'b0;
    chk("stray_stall", 32'(stall), 32'd0);
    chk("stray_op", 32'(op_class), 32'(C_I));
    chk("stray_valid", 32'(id_valid), 32'd1);
    Instruction_Code = W_ADD;
    tick();
    chk("stray_next_stall", 32'(stall), 32'd0);
    chk("stray_next_op", 32'(op_class), 32'(C_R));
    chk("stray_next_valid", 32'(id_valid), 32'd1);
    $display("stray knn_done stall=%0b op_class=%0d", stall, op_class);

    // ---------------- reset during kNN ----------------
    Instruction_Code = W_KNN1;
    tick();
    chk("rk_start", 32'(knn_start), 32'd1);
    chk("rk_rd", 32'(rd), 32'd3);
    Instruction_Code = W_ADD;
    tick();
    chk("rk_stall2", 32'(stall), 32'd1);
    chk("rk_rd_held", 32'(rd), 32'd3);
    chk("rk_rs1_held", 32'(rs1), 32'd1);
    tick();
    chk("rk_stall3", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("rk_in_reset_stall", 32'(stall), 32'd0);
    chk("rk_in_reset_start", 32'(knn_start), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("rk_after_stall", 32'(stall), 32'd0);
    chk("rk_after_valid", 32'(id_valid), 32'd0);
    chk("rk_after_op_nop", 32'(op_class), 32'(C_I));
    chk("rk_after_rd", 32'(rd), 32'd0);
    chk("rk_after_funct3", 32'(funct3), 32'd0);
    $display("reset mid-knn stall=%0b id_valid=%0b op_class=%0d", stall, id_valid, op_class);
    tick();
    chk("rk_resume_valid", 32'(id_valid), 32'd1);
    chk("rk_resume_op", 32'(op_class), 32'(C_R));
    chk("rk_resume_start", 32'(knn_start), 32'd0);
    chk("rk_resume_stall", 32'(stall), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter FLUSH_CYC, default 2, meaning the number of fetched words squashed after a taken branch.
REQ-002 SHALL have port clock  input  1  rising-edge clock for the whole block.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 SHALL have port Instruction_Code  input  32  fetched word, valid one cycle after the matching PC.
REQ-005 SHALL have port is_greater_than  input  1  branch compare result from execute.
REQ-006 SHALL have port knn_done  input  1  one-cycle pulse from the kNN accelerator when the custom operation completes.
REQ-007 SHALL have port pc_branch  output  1  branch request to fetch, asserted only in the decode cycle of a B-type instruction.
REQ-008 SHALL have port imm  output  12  backward branch distance for fetch: (-B_imm)[11:0].
REQ-009 SHALL have port id_valid  output  1  decoded bundle below is valid this cycle.
REQ-010 SHALL have port rs1, rs2, rd  output  5 each  register fields of the registered instruction.
REQ-011 SHALL have port funct3  output  3  and funct7  output  7  as the registered fields.
REQ-012 SHALL have port op_class  output  3  encoding one of R, I, LOAD, STORE, BRANCH, KNN, or ILLEGAL.
REQ-013 SHALL have port knn_start  output  1  one-cycle start pulse to the accelerator.
REQ-014 SHALL have port stall  output  1  asserted while the KNN state is active.

Function
REQ-015 SHALL register Instruction_Code into an IF/ID register on every clock edge when the state is RUN.
REQ-016 SHALL decode opcode bits [6:0] as follows: 0110011 is R, 0010011 is I, 0000011 is LOAD, 0100011 is STORE, 1100011 is BRANCH, 0001011 (custom-0) is KNN, and any other value is ILLEGAL.
REQ-017 SHALL assemble the B-immediate as {ir[31], ir[7], ir[30:25], ir[11:8], 0}, with 13 bits signed, and drive imm = two's-complement negation of that value truncated to 12 bits.
REQ-018 SHALL keep pc_branch combinationally gated by id_valid and op_class==BRANCH, so it is high for exactly one cycle per decoded branch.
REQ-019 SHALL implement the FSM states RUN, FLUSH, and KNN.
REQ-020 SHALL transition RUN->FLUSH when a branch is decoded and is_greater_than==1, loading the flush counter with FLUSH_CYC.
REQ-021 SHALL, in FLUSH, deassert id_valid, decrement the counter each cycle, and return to RUN when the counter reaches 0; FLUSH shall ignore the branch and KNN opcodes in squashed words.
REQ-022 SHALL, on a KNN decode in RUN, pulse knn_start for 1 cycle, enter KNN, assert stall, and hold the IF/ID register.
REQ-023 SHALL, in KNN, return to RUN on the knn_done cycle, with stall deasserting in the following cycle.
REQ-024 SHALL treat knn_done received in RUN or FLUSH as ignored, with no state change.
REQ-025 SHALL prioritise a taken branch over KNN entry, since both cannot be decoded in the same cycle.
REQ-026 SHALL, for ILLEGAL, set id_valid=1 and op_class=ILLEGAL, and leave the FSM unaffected.
REQ-027 SHALL give the fields of rs1, rs2, and rd the value 0 when op_class is not R, I, LOAD, STORE, BRANCH, or KNN.

Reset
REQ-028 SHALL, when reset==0 at the clock edge, set state to RUN, clear the IF/ID register to the NOP value 0x00000013, set the flush counter to 0, and set id_valid=0.
REQ-029 SHALL hold pc_branch, knn_start, and stall at 0 during reset.
REQ-030 SHALL abort an in-progress FLUSH or KNN on reset, with no knn_start pulse re-issued.
REQ-031 SHALL set id_valid to 1 from the first cycle after reset release when a fetched word is registered.

Structure
REQ-032 SHALL place the opcode constants, the op_class encoding, the state encoding, and the NOP constant in the shared package rv_pkg.
REQ-033 SHALL implement B/I/S immediate assembly in one sub-module, imm_gen, which is purely combinational and instantiated once.
REQ-034 SHALL fit the whole block within 150-300 RTL lines.

Verification
REQ-035 SHALL cover reset: hold reset=0 for 3 cycles with Instruction_Code=0xFFFFFFFF -> id_valid=0, pc_branch=0, stall=0; on release the first word decodes as ILLEGAL.
REQ-036 SHALL cover the branch-taken case: a BLT with offset -8 and is_greater_than=1 -> pc_branch=1 for 1 cycle, imm=0x008, and the next 2 words have id_valid=0.
REQ-037 SHALL cover the branch-not-taken case: the same BLT with is_greater_than=0 -> pc_branch pulses, there is no flush, and the next word has id_valid=1.
REQ-038 SHALL cover the KNN case: word 0x0000000B with knn_done arriving 5 cycles later -> knn_start for 1 cycle, stall for 6 cycles, and rd/rs1 held throughout.
REQ-039 SHALL cover a stray knn_done pulse in RUN -> no state change and stall stays 0.
REQ-040 SHALL cover reset mid-KNN: reset=0 on cycle 3 of stall -> the next cycle is RUN, stall=0, and the IF/ID register holds NOP.
